pwm_capture: RTL
================

Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM generator: measures an incoming PWM waveform instead of producing one.
- Synchronizes `pwm_in`, detects rising edges, and counts the period and high time in `clk` cycles.
- Converts each measurement into a DATA_WIDTH-bit duty code on the generator's scale, where 0 = 0% and 2^DATA_WIDTH-1 = 100%.
- Used for loopback checking of the generator and for reading external PWM sources.

Parameters:
- DATA_WIDTH, 8, duty code width; KMAX = 2^DATA_WIDTH-1.
- CNT_WIDTH, 16, width of the period and high-time counters.
- TIMEOUT, 50000, clk cycles without a rising edge before the input is declared stuck; must be <= 2^CNT_WIDTH-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- pwm_in  in  1  asynchronous PWM input.
- period_out  out  CNT_WIDTH  last measured period, in clk cycles.
- high_out  out  CNT_WIDTH  last measured high time, in clk cycles.
- meas_valid  out  1  one-cycle pulse when period_out/high_out update.
- duty_out  out  DATA_WIDTH  floor(high*KMAX/period), or 0/KMAX when stuck.
- duty_valid  out  1  one-cycle pulse when duty_out updates.
- stuck  out  1  high while the input has timed out; level shows in duty_out.
- overrun  out  1  one-cycle pulse when a measurement is dropped because the divider is busy.

Behaviour:
- Reset: all outputs 0, synchronizer flops 0, counters 0, state IDLE, divider idle. Reset mid-measurement discards everything; the first edge after reset produces no measurement.
- Input path: 2-flop synchronizer giving s. Edge detect: rise = s & ~s_d.
- State IDLE:
  - On rise: period_cnt <= 0, high_cnt <= 1, go to MEASURE.
  - stuck keeps its value.
- State MEASURE, each cycle without rise:
  - period_cnt += 1, saturating at 2^CNT_WIDTH-1.
  - high_cnt += s, saturating.
- State MEASURE, on rise:
  - period_out <= period_cnt+1 and high_out <= high_cnt, registered, so meas_valid pulses the cycle after rise.
  - Then period_cnt <= 0, high_cnt <= 1, stuck <= 0.
  - Same cycle: start the divider with numerator high_cnt*KMAX and denominator period_cnt+1.
- Timeout: when period_cnt reaches TIMEOUT in MEASURE (first cycle period_cnt == TIMEOUT):
  - Go to IDLE, stuck <= 1.
  - duty_out <= KMAX if s=1, else 0.
  - period_out <= 0, high_out <= 0.
  - duty_valid and meas_valid pulse once.
  - In IDLE after reset, no timeout is generated; stuck stays 0 until the first timeout.
- Divider latency: duty_valid pulses exactly DATA_WIDTH cycles after meas_valid. The quotient is <= KMAX because high <= period, so DATA_WIDTH quotient bits suffice.
- Busy divider: a rise completes a measurement while the divider is busy, i.e. a period shorter than DATA_WIDTH+1 cycles.
  - period_out/high_out/meas_valid still update.
  - The duty computation for that measurement is dropped and overrun pulses.
  - The in-flight division completes normally.
- Simultaneous events:
  - Divider result and timeout in the same cycle: timeout wins duty_out, one duty_valid pulse.
  - rise in the same cycle as period_cnt == TIMEOUT: rise wins, no timeout.

Optional Feature:
- Macro: PWM_CAPTURE_FILTER_EN.
- Defined:
  - A 3-sample majority filter sits after the synchronizer; s = majority of the last 3 synchronized samples.
  - Adds 1 cycle of edge latency.
  - Single-cycle glitches are suppressed.
- Undefined: s is the synchronizer output directly; glitches are measured as real edges.

Decomposition:
- Package pwm_pkg holds:
  - KMAX_VALUE as a function of DATA_WIDTH;
  - the capture state enum (IDLE, MEASURE);
  - the shared duty-scale constants, reused by the generator.
- Sub-module pwm_div_seq: sequential restoring divider, start/busy/done handshake, fixed DATA_WIDTH-cycle latency.

Test Plan:
All tests use DATA_WIDTH=8, CNT_WIDTH=16, TIMEOUT=1000, and the filter disabled unless stated.
- Steady PWM, period 100, high 25, after second rise: period_out=100, high_out=25; duty_out=63, with duty_valid 8 cycles after meas_valid.
- Input held 0 after one full cycle: after 1000 cycles without rise, stuck=1, duty_out=0, period_out=0, one duty_valid pulse.
- Input held 1 after a rise: at timeout, stuck=1, duty_out=255. The next rise clears stuck and later gives a normal measurement.
- Period 6, high 3 train: meas_valid every 6 cycles, overrun pulses on alternate measurements, and every duty_out produced equals 127.
- rst pulsed mid-MEASURE: outputs return to 0 immediately (asynchronous); the first rise after release gives no meas_valid, the second does.
- 1-cycle low glitch inside a 40-cycle high phase, period 100:
  - With PWM_CAPTURE_FILTER_EN: period_out=100, high_out=40.
  - Without: a spurious measurement is produced (period_out < 100).

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared duty-scale constants and capture state type for the PWM blocks
package pwm_pkg;

  // Duty code scale shared with the PWM generator: 0 = 0%, full scale = 100%.
  localparam int DUTY_WIDTH      = 8;
  localparam int DUTY_ZERO       = 0;
  localparam int DUTY_FULL_SCALE = (1 << DUTY_WIDTH) - 1;

  function automatic int kmax_value(input int data_width);
    return (1 << data_width) - 1;
  endfunction

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } cap_state_t;

endpackage

// File: rtl/pwm_div_seq.sv
// rtl/pwm_div_seq.sv - restoring divider, one quotient bit per cycle, MSB first
// Requires num < den * 2^Q_WIDTH; done is asserted combinationally in the last busy cycle.
module pwm_div_seq #(
  parameter int NUM_WIDTH = 24,
  parameter int DEN_WIDTH = 16,
  parameter int Q_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_WIDTH-1:0] num,
  input  logic [DEN_WIDTH-1:0] den,
  output logic                 busy,
  output logic                 done,
  output logic [Q_WIDTH-1:0]   quotient
);

  localparam int CW = $clog2(Q_WIDTH + 1);

  logic [NUM_WIDTH-1:0] rem;
  logic [NUM_WIDTH-1:0] dsh;
  logic [NUM_WIDTH-1:0] rem_step;
  logic [Q_WIDTH-2:0]   q;
  logic [CW-1:0]        cnt;
  logic                 take;

  always_comb begin
    take     = (rem >= dsh);
    rem_step = take ? (rem - dsh) : rem;
  end

  assign quotient = {q, take};
  assign done     = busy && (cnt == CW'(1));

  // The divisor starts shifted to the top quotient bit and walks down one bit per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      rem  <= '0;
      dsh  <= '0;
      q    <= '0;
      cnt  <= '0;
    end else if (busy) begin
      rem <= rem_step;
      dsh <= dsh >> 1;
      q   <= quotient[Q_WIDTH-2:0];
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
      end
    end else if (start) begin
      rem  <= num;
      dsh  <= NUM_WIDTH'(den) << (Q_WIDTH - 1);
      q    <= '0;
      cnt  <= CW'(Q_WIDTH);
      busy <= 1'b1;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures period, high time and duty code of an incoming PWM waveform
// Optional PWM_CAPTURE_FILTER_EN inserts a 3-sample majority filter after the synchronizer.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int DATA_WIDTH = DUTY_WIDTH,
  parameter int CNT_WIDTH  = 16,
  parameter int TIMEOUT    = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pwm_in,
  output logic [CNT_WIDTH-1:0]  period_out,
  output logic [CNT_WIDTH-1:0]  high_out,
  output logic                  meas_valid,
  output logic [DATA_WIDTH-1:0] duty_out,
  output logic                  duty_valid,
  output logic                  stuck,
  output logic                  overrun
);

  localparam int                    KMAX          = kmax_value(DATA_WIDTH);
  localparam int                    NUM_WIDTH     = CNT_WIDTH + DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX       = '1;
  localparam logic [CNT_WIDTH-1:0]  TIMEOUT_CNT   = CNT_WIDTH'(TIMEOUT);
  localparam logic [DATA_WIDTH-1:0] DUTY_MAX_CODE = DATA_WIDTH'(KMAX);

  cap_state_t state;
  cap_state_t state_next;

  logic                  sync1;
  logic                  sync2;
  logic                  s;
  logic                  s_d;
  logic                  rise;
  logic [CNT_WIDTH-1:0]  period_cnt;
  logic [CNT_WIDTH-1:0]  high_cnt;
  logic [CNT_WIDTH-1:0]  period_meas;
  logic                  do_restart;
  logic                  do_capture;
  logic                  do_timeout;
  logic                  div_start;
  logic                  div_busy;
  logic                  div_done;
  logic [DATA_WIDTH-1:0] div_q;
  logic [NUM_WIDTH-1:0]  div_num;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  logic [1:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
    end else begin
      hist <= {hist[0], sync2};
    end
  end

  assign s = (sync2 & hist[0]) | (sync2 & hist[1]) | (hist[0] & hist[1]);
`else
  assign s = sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_d <= 1'b0;
    end else begin
      s_d <= s;
    end
  end

  assign rise        = s & ~s_d;
  assign period_meas = (period_cnt == CNT_MAX) ? CNT_MAX : period_cnt + CNT_WIDTH'(1);
  assign div_num     = NUM_WIDTH'(high_cnt) * NUM_WIDTH'(KMAX);
  assign div_start   = do_capture & ~div_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A rise always beats the timeout compare in the same cycle.
  always_comb begin
    state_next = state;
    do_restart = 1'b0;
    do_capture = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          do_restart = 1'b1;
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          do_restart = 1'b1;
          do_capture = 1'b1;
        end else if (period_cnt == TIMEOUT_CNT) begin
          do_timeout = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
      high_cnt   <= '0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      duty_out   <= '0;
      duty_valid <= 1'b0;
      stuck      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      duty_valid <= 1'b0;
      overrun    <= 1'b0;

      if (do_restart) begin
        period_cnt <= '0;
        high_cnt   <= CNT_WIDTH'(1);
      end else if (state == MEASURE) begin
        if (period_cnt != CNT_MAX) begin
          period_cnt <= period_cnt + CNT_WIDTH'(1);
        end
        if (s && (high_cnt != CNT_MAX)) begin
          high_cnt <= high_cnt + CNT_WIDTH'(1);
        end
      end

      if (do_capture) begin
        period_out <= period_meas;
        high_out   <= high_cnt;
        meas_valid <= 1'b1;
        stuck      <= 1'b0;
        overrun    <= div_busy;
      end

      // Timeout owns duty_out even if a division finishes in the same cycle.
      if (do_timeout) begin
        period_out <= '0;
        high_out   <= '0;
        meas_valid <= 1'b1;
        stuck      <= 1'b1;
        duty_out   <= s ? DUTY_MAX_CODE : '0;
        duty_valid <= 1'b1;
      end else if (div_done) begin
        duty_out   <= div_q;
        duty_valid <= 1'b1;
      end
    end
  end

  pwm_div_seq #(
    .NUM_WIDTH (NUM_WIDTH),
    .DEN_WIDTH (CNT_WIDTH),
    .Q_WIDTH   (DATA_WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .num      (div_num),
    .den      (period_meas),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

endmodule
